// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states, RV32I lane select/extend
// Optional: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [AW-1:0] idx;
  logic [31:0]   rword, rshift, ext_data, wr_data;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [3:0]    be;
  logic          illegal, misalign, err;

  // Upper address bits are deliberately discarded so addresses alias modulo 4*DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign accept = req_valid && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT:   if (cnt == 4'd0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign idx = r_addr[AW+1:2];

  always_comb begin
    illegal = 1'b1;
    case (r_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
      default:                                illegal = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                    ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err = illegal || misalign;

  // Load path: pick the addressed lane, then extend per funct3.
  assign rword  = mem[idx];
  assign rshift = rword >> {r_addr[1:0], 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = r_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ext_data = 32'd0;
    case (r_funct3)
      3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext_data = {24'd0, rbyte};
      3'b001:  ext_data = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext_data = {16'd0, rhalf};
      3'b010:  ext_data = rword;
      default: ext_data = 32'd0;
    endcase
  end

  // Store path: replicate right-aligned data across lanes, enable only the addressed ones.
  always_comb begin
    be      = 4'b0000;
    wr_data = 32'd0;
    case (r_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << r_addr[1:0];
        wr_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        be      = r_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        be      = 4'b1111;
        wr_data = r_wdata;
      end
      default: begin
        be      = 4'b0000;
        wr_data = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_ACCESS && r_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[AW+1:0];
            r_wdata  <= req_wdata;
            cnt      <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_ACCESS: begin
          rsp_err   <= err;
          rsp_rdata <= (r_we || err) ? 32'd0 : ext_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH       = 1024;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_rsp(input string tag, input int hold);
    int k;
    logic [31:0] held;
    exp_t e;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, WAIT_CYCLES + 1);
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = $urandom_range(0, 255) << 2; req_wdata = $urandom;
      chk({tag, "_bp_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_bp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_bp_rdata"}, rsp_rdata, held);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, {31'd0, rsp_valid ^ 1'b1});
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_valid_clr"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_idle"}, {30'd0, busy, req_ready}, 32'd1);
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int hold);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    sb_q.push_back(e);
    start_req(we, f3, a, wd);
    finish_rsp(tag, hold);
  endtask

  initial begin
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    xact("sb13", 1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0, 0);
    xact("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 0);
    xact("lw10_bp", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 5);

    xact("sw20", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    xact("ill011_st", 1'b1, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 0);
    xact("ill110_ld", 1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1, 0);
    xact("lw20_kept", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    xact("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFCAFE, 1'b0, 0);
    xact("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000CAFE, 1'b0, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
    xact("sh21_mis", 1'b1, 3'b001, 32'h21, 32'h00001234, 32'h0, 1'b1, 0);
    xact("lw20_mis", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);
`else
    xact("sh21_mis", 1'b1, 3'b001, 32'h21, 32'h00001234, 32'h0, 1'b0, 0);
    xact("lw20_mis", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE1234, 1'b0, 0);
`endif

    xact("sw30", 1'b1, 3'b010, 32'h30, 32'h11223344, 32'h0, 1'b0, 0);
    xact("lw30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h11223344, 1'b0, 0);

    start_req(1'b1, 3'b010, 32'h30, 32'hFFFFFFFF);
    #2 rst = 1'b0;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rdata", rsp_rdata, 32'd0);
    chk("arst_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    xact("lw30_after_rst", 1'b0, 3'b010, 32'h30, 32'h0, 32'h11223344, 1'b0, 0);
    xact("lw30_alias", 1'b0, 3'b010, 32'h30 + 4 * DEPTH, 32'h0, 32'h11223344, 1'b0, 0);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
